// File: rtl/rc5_dec_core.sv
// RC5-32 decryption core with on-chip key expansion (b = 16 byte key).
// Optional macro RC5_DEC_FULL_ROUND_EN: when defined, each ROUND cycle
// performs a full round (both halves); otherwise one half-round per cycle.
module rc5_dec_core #(
  parameter int unsigned ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         key_en,
  output logic         key_ok,
  input  logic [63:0]  din,
  input  logic         din_en,
  output logic         din_rdy,
  output logic [63:0]  dout,
  output logic         dout_en
);

  localparam int unsigned T         = 2 * ROUNDS + 2;
  localparam int unsigned MIX_STEPS = 3 * T;
  localparam int unsigned IW        = $clog2(T);
  localparam int unsigned CW        = $clog2(MIX_STEPS);
  localparam int unsigned KW        = $clog2(ROUNDS + 1);
  localparam logic [31:0] P32       = 32'hB7E15163;
  localparam logic [31:0] Q32       = 32'h9E3779B9;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MIX,
    READY,
    ROUND,
    FINAL
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   s_tab [T];
  logic [31:0]   l_tab [4];
  logic [31:0]   a_reg, b_reg;
  logic [31:0]   init_val;
  logic [IW-1:0] i_idx;
  logic [1:0]    j_idx;
  logic [CW-1:0] step;
  logic [KW-1:0] k_idx;
`ifndef RC5_DEC_FULL_ROUND_EN
  logic          phase;
`endif

  logic [31:0]   mix_a, mix_ab, mix_b;
  logic [IW-1:0] idx_even, idx_odd;
  logic [31:0]   hb, ha, ha_key;
  logic          init_last, mix_last, round_last;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  assign din_rdy = (state == READY) && key_ok;

  // Key-mix step and decryption round datapath.
  always_comb begin
    mix_a     = rotl(s_tab[i_idx] + a_reg + b_reg, 5'd3);
    mix_ab    = mix_a + b_reg;
    mix_b     = rotl(l_tab[j_idx] + mix_ab, mix_ab[4:0]);
    idx_even  = IW'({k_idx, 1'b0});
    idx_odd   = idx_even | IW'(1);
    hb        = rotr(b_reg - s_tab[idx_odd], a_reg[4:0]) ^ a_reg;
`ifdef RC5_DEC_FULL_ROUND_EN
    ha_key    = hb;
`else
    ha_key    = b_reg;
`endif
    ha        = rotr(a_reg - s_tab[idx_even], ha_key[4:0]) ^ ha_key;
    init_last = (i_idx == IW'(T - 1));
    mix_last  = (step == CW'(MIX_STEPS - 1));
`ifdef RC5_DEC_FULL_ROUND_EN
    round_last = (k_idx == KW'(1));
`else
    round_last = phase && (k_idx == KW'(1));
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a key load overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (key_en) begin
      state_nxt = INIT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        INIT:    if (init_last) state_nxt = MIX;
        MIX:     if (mix_last) state_nxt = READY;
        READY:   if (din_en) state_nxt = ROUND;
        ROUND:   if (round_last) state_nxt = FINAL;
        FINAL:   state_nxt = READY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Tables, working registers, counters and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < T; n++) s_tab[n] <= '0;
      for (int unsigned n = 0; n < 4; n++) l_tab[n] <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      init_val <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      step     <= '0;
      k_idx    <= '0;
`ifndef RC5_DEC_FULL_ROUND_EN
      phase    <= 1'b0;
`endif
      key_ok   <= 1'b0;
      dout     <= '0;
      dout_en  <= 1'b0;
    end else begin
      dout_en <= 1'b0;
      if (key_en) begin
        l_tab[0] <= key[31:0];
        l_tab[1] <= key[63:32];
        l_tab[2] <= key[95:64];
        l_tab[3] <= key[127:96];
        key_ok   <= 1'b0;
        init_val <= P32;
        a_reg    <= '0;
        b_reg    <= '0;
        i_idx    <= '0;
        j_idx    <= '0;
        step     <= '0;
        k_idx    <= '0;
`ifndef RC5_DEC_FULL_ROUND_EN
        phase    <= 1'b0;
`endif
      end else begin
        case (state)
          INIT: begin
            s_tab[i_idx] <= init_val;
            init_val     <= init_val + Q32;
            i_idx        <= init_last ? '0 : i_idx + 1'b1;
          end
          MIX: begin
            s_tab[i_idx] <= mix_a;
            l_tab[j_idx] <= mix_b;
            a_reg        <= mix_a;
            b_reg        <= mix_b;
            i_idx        <= (i_idx == IW'(T - 1)) ? '0 : i_idx + 1'b1;
            j_idx        <= j_idx + 1'b1;
            if (mix_last) begin
              step   <= '0;
              key_ok <= 1'b1;
            end else begin
              step   <= step + 1'b1;
            end
          end
          READY: begin
            if (din_en) begin
              a_reg <= din[31:0];
              b_reg <= din[63:32];
              k_idx <= KW'(ROUNDS);
`ifndef RC5_DEC_FULL_ROUND_EN
              phase <= 1'b0;
`endif
            end
          end
          ROUND: begin
`ifdef RC5_DEC_FULL_ROUND_EN
            a_reg <= ha;
            b_reg <= hb;
            k_idx <= k_idx - 1'b1;
`else
            if (!phase) begin
              b_reg <= hb;
              phase <= 1'b1;
            end else begin
              a_reg <= ha;
              phase <= 1'b0;
              k_idx <= k_idx - 1'b1;
            end
`endif
          end
          FINAL: begin
            dout    <= {b_reg - s_tab[1], a_reg - s_tab[0]};
            dout_en <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rc5_dec_core.md
RC5_DEC_CORE -- requirements
Module: rc5_dec_core

Interface
REQ-001 The module SHALL have parameter ROUNDS, default 12, giving the RC5-32 round count; its S-table size is 2*ROUNDS+2 words.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 key  input  128  secret key; L[0]=key[31:0] ... L[3]=key[127:96].
REQ-005 key_en  input  1  one-cycle strobe that loads key and starts key expansion.
REQ-006 key_ok  output  1  high when the expanded key table is valid.
REQ-007 din  input  64  ciphertext block; A=din[31:0], B=din[63:32].
REQ-008 din_en  input  1  block-valid strobe, accepted only while din_rdy=1.
REQ-009 din_rdy  output  1  high when key_ok=1 and no block is in flight.
REQ-010 dout  output  64  plaintext block {B,A}, held until the next result.
REQ-011 dout_en  output  1  one-cycle strobe marking dout valid.

Function
REQ-012 States SHALL be IDLE, INIT, MIX, READY, ROUND and FINAL.
REQ-013 key_en in any state SHALL latch key, clear key_ok, abort any in-flight block without a dout_en, and enter INIT.
REQ-014 INIT SHALL take 2*ROUNDS+2 cycles and write S[0]=0xB7E15163 and S[i]=S[i-1]+0x9E3779B9 (mod 2^32).
REQ-015 MIX SHALL take 3*(2*ROUNDS+2) cycles, one step per cycle, with A=B=0 and i,j=0 at entry.
REQ-016 Each MIX step SHALL compute A=S[i]=(S[i]+A+B)<<<3 and B=L[j]=(L[j]+A+B)<<<((A+B) mod 32), with i wrapping mod 2*ROUNDS+2 and j wrapping mod 4.
REQ-017 key_ok SHALL assert on the cycle after the last MIX step and the FSM SHALL enter READY; with default ROUNDS that is 104 cycles after key_en is sampled.
REQ-018 din_en sampled with din_rdy=1 SHALL capture A and B, set round index k=ROUNDS, and enter ROUND.
REQ-019 Each half-round SHALL run in order: B=((B-S[2k+1])>>>(A mod 32))^A, then A=((A-S[2k])>>>(B mod 32))^B, then k decrements.
REQ-020 After k=1 completes, FINAL SHALL compute B=B-S[1] and A=A-S[0], register dout={B,A}, pulse dout_en, and return to READY.
REQ-021 din_en with din_rdy=0 SHALL be ignored with no state change.
REQ-022 If key_en and din_en arrive in the same cycle, key_en SHALL win and din SHALL be dropped.
REQ-023 All additions and subtractions SHALL be mod 2^32, and rotate amounts SHALL use only the low 5 bits.
REQ-024 dout_en SHALL never be high for two consecutive cycles.

Reset
REQ-025 rst SHALL force state IDLE, key_ok=0, din_rdy=0, dout=0, dout_en=0, the S and L tables to 0, and all counters to 0, immediately and independent of clk.
REQ-026 On release of rst, the block SHALL stay in IDLE until key_en, with din_en ignored.
REQ-027 rst asserted mid-INIT, mid-MIX or mid-ROUND SHALL discard all progress; no dout_en SHALL follow.

Configuration
REQ-028 With macro RC5_DEC_FULL_ROUND_EN defined, ROUND SHALL execute both half-rounds of REQ-019 combinationally in one cycle, so dout_en is high ROUNDS+1 cycles after the din_en sample (13 by default).
REQ-029 Without RC5_DEC_FULL_ROUND_EN, ROUND SHALL execute one half-round per cycle, so dout_en is high 2*ROUNDS+1 cycles after the din_en sample (25 by default).
REQ-030 Key-expansion timing and all results SHALL be identical with and without the macro.

Verification
REQ-031 The bench SHALL cover this known-answer test: key=0 -> key_ok after 104 cycles; din=64'h6D8F4B15_EEDBA521 -> dout=64'h0, one dout_en pulse.
REQ-032 The bench SHALL cover round-trip: 100 random keys and blocks, each encrypted by the RC5 reference model and fed in -> dout equals the original plaintext, with latency exactly 13 or 25 cycles per REQ-028/029.
REQ-033 The bench SHALL cover key_en issued 5 cycles into a block -> no dout_en, key_ok=0 next cycle, then a correct result under the new key.
REQ-034 The bench SHALL cover din_en while busy or before key_ok -> ignored: no dout_en, and dout keeps its previous value.
REQ-035 The bench SHALL cover rst pulsed mid-MIX and mid-ROUND -> all outputs 0 immediately; key_en is then required before din_rdy=1.
REQ-036 The bench SHALL cover key_en and din_en in the same cycle -> only key expansion starts; no dout_en.
